// File: rtl/trace_buffer.sv
// Retire-trace capture FIFO: stamps commit events with seq/cycle
// and hands them to a trace sink over a valid/ready handshake.
module trace_buffer #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 16,
  parameter int SEQ_W        = 32,
  parameter int CYC_W        = 32,
  parameter bit STALL_MODE   = 1'b1,
  parameter int STALL_MARGIN = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trace_en,
  input  logic                   valid,
  input  logic [XLEN-1:0]        pc,
  input  logic [31:0]            inst,
  input  logic                   rdv,
  input  logic [4:0]             rd_x,
  input  logic [XLEN-1:0]        rd_data,
  input  logic                   pcv,
  input  logic [XLEN-1:0]        pc_x,
  output logic                   stall,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SEQ_W-1:0]       out_seq,
  output logic [CYC_W-1:0]       out_cycle,
  output logic [XLEN-1:0]        out_pc,
  output logic [31:0]            out_inst,
  output logic                   out_rdv,
  output logic [4:0]             out_rd_x,
  output logic [XLEN-1:0]        out_rd_data,
  output logic                   out_pcv,
  output logic [XLEN-1:0]        out_pc_x,
  output logic                   out_lost,
  output logic [15:0]            drop_count,
  output logic [$clog2(DEPTH):0] level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic             lost;
    logic [SEQ_W-1:0] seq;
    logic [CYC_W-1:0] cyc;
    logic [XLEN-1:0]  pc;
    logic [31:0]      inst;
    logic             rdv;
    logic [4:0]       rd_x;
    logic [XLEN-1:0]  rd_data;
    logic             pcv;
    logic [XLEN-1:0]  pc_x;
  } rec_t;

  rec_t             mem_q [DEPTH];
  rec_t             rec_in;
  rec_t             head;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [15:0]      drop_q, drop_d;
  logic             lost_q, lost_d;
  logic             push_req, pop, full;
  logic             accept, drop;

  assign out_valid = (level_q != '0);

  always_comb begin
    push_req = trace_en & (valid | rdv | pcv);
    full     = (level_q == LW'(DEPTH));
    pop      = out_valid & out_ready;
    accept   = push_req & (~full | pop);
    drop     = push_req & ~accept;
  end

  // unqualified fields are zeroed so the sink never sees stale data
  always_comb begin
    rec_in      = '0;
    rec_in.lost = lost_q;
    rec_in.seq  = seq_q;
    rec_in.cyc  = cyc_q;
    if (valid) begin
      rec_in.pc   = pc;
      rec_in.inst = inst;
    end
    if (rdv) begin
      rec_in.rdv     = 1'b1;
      rec_in.rd_x    = rd_x;
      rec_in.rd_data = rd_data;
    end
    if (pcv) begin
      rec_in.pcv  = 1'b1;
      rec_in.pc_x = pc_x;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(accept);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    level_d  = level_q + LW'(accept) - LW'(pop);
    seq_d    = seq_q + SEQ_W'(accept);
    cyc_d    = cyc_q + CYC_W'(1);
    drop_d   = drop_q;
    if (drop && drop_q != 16'hFFFF)
      drop_d = drop_q + 16'd1;
    lost_d = lost_q;
    if (drop)
      lost_d = 1'b1;
    else if (accept)
      lost_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      seq_q    <= '0;
      cyc_q    <= '0;
      drop_q   <= '0;
      lost_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      seq_q    <= seq_d;
      cyc_q    <= cyc_d;
      drop_q   <= drop_d;
      lost_q   <= lost_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      mem_q[wr_ptr_q] <= rec_in;
  end

  assign head        = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_seq     = head.seq;
  assign out_cycle   = head.cyc;
  assign out_pc      = head.pc;
  assign out_inst    = head.inst;
  assign out_rdv     = head.rdv;
  assign out_rd_x    = head.rd_x;
  assign out_rd_data = head.rd_data;
  assign out_pcv     = head.pcv;
  assign out_pc_x    = head.pc_x;
  assign out_lost    = head.lost;
  assign drop_count  = drop_q;
  assign level       = level_q;

  assign stall = STALL_MODE ?
    (level_q >= LW'(DEPTH - STALL_MARGIN)) : 1'b0;

endmodule

// File: tb/tb_trace_buffer.sv
// Bench for trace_buffer: a stalling 32-bit instance and a
// dropping instance with 4-bit stamps share one stimulus.
module tb_trace_buffer;
  logic clk = 1'b0, reset = 1'b0, trace_en = 1'b0;
  logic valid = 1'b0, rdv = 1'b0, pcv = 1'b0, out_ready = 1'b0;
  logic [31:0] pc = '0, inst = '0, rd_data = '0, pc_x = '0;
  logic [4:0]  rd_x = '0;

  logic a_stall, a_ov, a_rdv, a_pcv, a_lost;
  logic [31:0] a_seq, a_cyc, a_pc, a_inst, a_rdd, a_pcx;
  logic [4:0]  a_rdx, a_level;
  logic [15:0] a_drop;

  logic b_stall, b_ov, b_rdv, b_pcv, b_lost;
  logic [3:0]  b_seq, b_cyc;
  logic [31:0] b_pc, b_inst, b_rdd, b_pcx;
  logic [4:0]  b_rdx, b_level;
  logic [15:0] b_drop;

  int n_vec = 0, n_err = 0;

  typedef struct {
    logic [31:0] seq, cyc, pc, inst, rdd, pcx;
    logic [4:0]  rdx;
    logic        rdv, pcv, lost;
  } exp_t;
  exp_t sb[$];
  int          m_level = 0;
  logic [31:0] m_seq = '0, cyc = '0;
  logic        m_lost = 1'b0;

  trace_buffer u_a (
    .clk(clk), .reset(reset), .trace_en(trace_en),
    .valid(valid), .pc(pc), .inst(inst), .rdv(rdv),
    .rd_x(rd_x), .rd_data(rd_data), .pcv(pcv), .pc_x(pc_x),
    .stall(a_stall), .out_valid(a_ov), .out_ready(out_ready),
    .out_seq(a_seq), .out_cycle(a_cyc), .out_pc(a_pc),
    .out_inst(a_inst), .out_rdv(a_rdv), .out_rd_x(a_rdx),
    .out_rd_data(a_rdd), .out_pcv(a_pcv), .out_pc_x(a_pcx),
    .out_lost(a_lost), .drop_count(a_drop), .level(a_level)
  );

  trace_buffer #(
    .SEQ_W(4), .CYC_W(4), .STALL_MODE(1'b0)
  ) u_b (
    .clk(clk), .reset(reset), .trace_en(trace_en),
    .valid(valid), .pc(pc), .inst(inst), .rdv(rdv),
    .rd_x(rd_x), .rd_data(rd_data), .pcv(pcv), .pc_x(pc_x),
    .stall(b_stall), .out_valid(b_ov), .out_ready(out_ready),
    .out_seq(b_seq), .out_cycle(b_cyc), .out_pc(b_pc),
    .out_inst(b_inst), .out_rdv(b_rdv), .out_rd_x(b_rdx),
    .out_rd_data(b_rdd), .out_pcv(b_pcv), .out_pc_x(b_pcx),
    .out_lost(b_lost), .drop_count(b_drop), .level(b_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int k, input logic rdy);
    logic [31:0] kv;
    kv = k;
    trace_en = 1'b1;
    valid = (k % 4 != 3);
    rdv = kv[0];
    pcv = kv[1];
    pc = 32'h100 + kv * 4;
    inst = 32'h13 | (kv << 7);
    rd_x = kv[4:0];
    rd_data = ~kv;
    pc_x = kv << 8;
    out_ready = rdy;
  endtask

  task automatic idle(input logic rdy);
    valid = 1'b0;
    rdv = 1'b0;
    pcv = 1'b0;
    out_ready = rdy;
  endtask

  // scoreboard update for the coming edge, then advance one clk
  task automatic tick();
    logic pr, pp, acc;
    exp_t e;
    pr = trace_en & (valid | rdv | pcv);
    pp = (m_level != 0) && out_ready;
    acc = pr && (m_level < 16 || pp);
    if (pp) begin
      e = sb.pop_front();
      check("a_seq", a_seq, e.seq);
      check("a_cyc", a_cyc, e.cyc);
      check("a_pc", a_pc, e.pc);
      check("a_inst", a_inst, e.inst);
      check("a_rdv", a_rdv, e.rdv);
      check("a_rdx", a_rdx, e.rdx);
      check("a_rdd", a_rdd, e.rdd);
      check("a_pcv", a_pcv, e.pcv);
      check("a_pcx", a_pcx, e.pcx);
      check("a_lost", a_lost, e.lost);
      check("b_seq", b_seq, e.seq[3:0]);
      check("b_cyc", b_cyc, e.cyc[3:0]);
      check("b_pc", b_pc, e.pc);
      check("b_lost", b_lost, e.lost);
    end
    if (acc) begin
      e.seq = m_seq;
      e.cyc = cyc;
      e.pc = valid ? pc : '0;
      e.inst = valid ? inst : '0;
      e.rdv = rdv;
      e.rdx = rdv ? rd_x : '0;
      e.rdd = rdv ? rd_data : '0;
      e.pcv = pcv;
      e.pcx = pcv ? pc_x : '0;
      e.lost = m_lost;
      sb.push_back(e);
      m_seq++;
      m_lost = 1'b0;
    end else if (pr) begin
      m_lost = 1'b1;
    end
    m_level = m_level + int'(acc) - int'(pp);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [31:0] t0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_level", a_level, 0);
    check("rst_ov", a_ov, 0);
    check("rst_stall", a_stall, 0);
    check("rst_drop", a_drop, 0);
    check("rst_pc", a_pc, 0);
    reset = 1'b1;
    cyc = '0;

    repeat (3) tick();
    trace_en = 1'b1;
    valid = 1'b1; pc = 32'h80; inst = 32'h00500093;
    rdv = 1'b1; rd_x = 5'd1; rd_data = 32'd5;
    pcv = 1'b0; pc_x = 32'hdead;
    tick();
    check("one_ov", a_ov, 1);
    check("one_seq", a_seq, 0);
    check("one_cyc", a_cyc, 3);
    check("one_pc", a_pc, 32'h80);
    check("one_inst", a_inst, 32'h00500093);
    check("one_rdd", a_rdd, 5);
    check("one_pcx", a_pcx, 0);
    check("one_level", a_level, 1);
    idle(1'b1);
    tick();
    check("one_pop", a_level, 0);

    for (int k = 0; k < 16; k++) begin
      drive(k, 1'b0);
      tick();
      check("fill_level", a_level, k + 1);
      check("fill_stall", a_stall, (k + 1 >= 14));
      check("fill_bstall", b_stall, 0);
    end
    for (int j = 0; j < 3; j++) begin
      drive(16 + j, 1'b0);
      tick();
      check("ovf_drop", a_drop, j + 1);
      check("ovf_bdrop", b_drop, j + 1);
      check("ovf_level", a_level, 16);
      check("ovf_stall", a_stall, 1);
      check("ovf_bstall", b_stall, 0);
    end
    idle(1'b1);
    tick();
    check("pop1_level", a_level, 15);
    check("pop1_stall", a_stall, 1);
    drive(19, 1'b0);
    tick();
    check("lost_level", a_level, 16);
    check("lost_drop", a_drop, 3);

    for (int i = 0; i < 40; i++) begin
      drive(20 + i, 1'b1);
      tick();
      check("wrap_level", a_level, 16);
      check("wrap_drop", a_drop, 3);
      if (i == 14) begin
        check("lost_hd", a_lost, 1);
        check("lost_seq", a_seq, 17);
        check("lost_bseq", b_seq, 1);
      end
      if (i == 15) begin
        check("next_lost", a_lost, 0);
        check("next_seq", a_seq, 18);
      end
    end
    idle(1'b1);
    repeat (16) tick();
    check("drain_level", a_level, 0);
    check("drain_ov", a_ov, 0);
    check("drain_stall", a_stall, 0);

    t0 = cyc;
    drive(60, 1'b0);
    tick();
    check("en_cyc0", a_cyc, t0);
    trace_en = 1'b0;
    repeat (5) tick();
    check("en_level", a_level, 1);
    check("en_drop", a_drop, 3);
    drive(61, 1'b1);
    tick();
    check("en_cyc1", a_cyc, t0 + 6);
    t0 = t0 + 6;
    check("en_bcyc1", b_cyc, t0[3:0]);
    idle(1'b1);
    tick();
    check("en_empty", a_level, 0);

    for (int k = 0; k < 7; k++) begin
      drive(70 + k, 1'b0);
      tick();
    end
    check("pre_rst_level", a_level, 7);
    idle(1'b0);
    #3 reset = 1'b0;
    #1;
    check("arst_level", a_level, 0);
    check("arst_ov", a_ov, 0);
    check("arst_drop", a_drop, 0);
    check("arst_bdrop", b_drop, 0);
    check("arst_seq", a_seq, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    m_level = 0;
    m_seq = '0;
    m_lost = 1'b0;
    cyc = '0;
    drive(80, 1'b0);
    tick();
    check("post_level", a_level, 1);
    check("post_seq", a_seq, 0);
    check("post_cyc", a_cyc, 0);
    check("post_lost", a_lost, 0);
    idle(1'b1);
    tick();
    check("post_empty", a_level, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
